div8: RTL and testbench
=======================

# div8

Sequential 8-bit unsigned divider built by repeated shift-and-subtract. It is the inverse of the add-and-register accumulator datapath: that path builds a total by repeated addition, and this block breaks a total down by repeated subtraction into quotient and remainder. It sits beside the accumulator in the arithmetic datapath. It uses a start/busy/done handshake so a controller can feed it the accumulator output and collect the results.

## Interface
- WIDTH, 8, operand and result width (all values below assume 8)
- clk  in  1  rising-edge clock
- clear  in  1  reset, asynchronous, active-high; forces idle and zeros all outputs
- start  in  1  request a division; sampled on rising clk edges
- dividend  in  8  unsigned dividend, sampled only on the accepting edge
- divisor  in  8  unsigned divisor, sampled only on the accepting edge
- quot  out  8  registered quotient
- rem  out  8  registered remainder
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle pulse; quot/rem/dz are valid from this cycle
- dz  out  1  divide-by-zero flag for the last completed operation

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1 and divisor≠0:
  - latch dividend into shift register Q and divisor into D
  - partial remainder R=0, iteration counter=0
  - go to RUN; busy=1
- IDLE with start=1 and divisor=0:
  - go to DONE without any RUN cycles
  - quot=8'hFF, rem=dividend, dz=1
- RUN, one iteration per cycle:
  - {R,Q} shifted left one bit
  - trial = R_shifted − D, computed by sub8 with borrow-in 0
  - no borrow-out: R=trial and Q[0]=1; otherwise R is kept and Q[0]=0
  - counter increments; after the 8th iteration: quot=Q, rem=R, dz=0, go to DONE
- DONE:
  - done=1 and busy=0 for exactly one cycle, then go to IDLE
  - start is also accepted in DONE, with the same rules as IDLE, so back-to-back operations lose no extra cycle
- start while in RUN is ignored; operands are not re-sampled.
- quot/rem/dz hold their values until the next completion or clear.
- Arithmetic is unsigned only. R never exceeds D−1 after an iteration. The borrow is used internally and is not an output.

## Timing
- Reset values: quot=0, rem=0, busy=0, done=0, dz=0; state=IDLE; counter=0.
- clear asserted at any time, including mid-RUN:
  - immediate abort; no done pulse
  - the in-flight result is discarded
  - the first start is accepted on the first rising edge after clear deasserts
- Accepting edge E with divisor≠0:
  - busy=1 after E
  - iterations on edges E+1..E+8
  - quot/rem update and done=1 after E+8
  - busy=0 after E+8; done=0 after E+9
  - latency is 8 cycles from acceptance to done
- Accepting edge E with divisor=0: done=1 after E+1; latency is 1 cycle.
- Counter is 3 bits and wraps 7→0 on the final iteration; the wrap is the termination condition.
- All outputs are registered; no combinational path from input to output.

## Structure
- Sub-module sub8(diff, bout, a, b, bin): combinational, {bout,diff} = a − b − bin. It mirrors the existing add8 port order and is reused later by a subtract-mode accumulator.
- Shared arithmetic package:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - the WIDTH default
  - DZ_QUOT = 8'hFF
- The top holds the FSM, the counter and the Q/R/D registers. The only register inside it that is not reset is D, which is don't-care while idle.

## Test plan
- clear, then 200/7 → after 8 cycles done pulses once; quot=28, rem=4, dz=0; busy high for exactly 8 cycles.
- 255/1 then 5/9 back-to-back, with start held in the DONE cycle → quot=255, rem=0; then quot=0, rem=5; second done 9 cycles after the first.
- 100/0 → done 1 cycle after acceptance; quot=8'hFF, rem=100, dz=1. A following 9/3 clears dz: quot=3, rem=0, dz=0.
- Start 77/5, then pulse start with 10/2 at RUN cycle 3 → second request ignored; result quot=15, rem=2.
- Start 250/3, assert clear asynchronously mid-cycle at RUN cycle 4 → all outputs 0 immediately, no done. After release, 250/3 → quot=83, rem=1.
- Random sweep of 1000 operand pairs with divisor≠0 → quot*divisor+rem == dividend and rem<divisor on every done.

Source files
------------

// File: rtl/div8_pkg.sv
// Shared arithmetic constants for the divider datapath.
package div8_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    // FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Quotient reported on divide-by-zero
    localparam logic [WIDTH_DEF-1:0] DZ_QUOT = 8'hFF;

endpackage

// File: rtl/sub8.sv
// Combinational subtractor: {bout,diff} = a - b - bin (port order mirrors add8).
module sub8 #(
    parameter int unsigned W = 8
) (
    output logic [W-1:0] diff,
    output logic         bout,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin
);

    // Widen by one bit so the top bit of the result is the borrow
    assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};

endmodule

// File: rtl/div8.sv
// Sequential unsigned shift-and-subtract divider with start/busy/done handshake.
module div8
    import div8_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic             dzp_q, dzp_d;
    logic             can_accept;

    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] trial;
    logic             bout;

    // R shifted left with the next dividend bit from the top of Q
    assign r_sh = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    sub8 #(.W(WIDTH)) u_sub (
        .diff (trial),
        .bout (bout),
        .a    (r_sh),
        .b    (d_q),
        .bin  (1'b0)
    );

    // Next-state, datapath and output-register next values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        r_d        = r_q;
        d_d        = d_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        dzp_d      = 1'b0;
        can_accept = 1'b0;

        case (state_q)
            S_IDLE: begin
                can_accept = 1'b1;
            end
            S_RUN: begin
                busy_d = 1'b1;
                r_d    = bout ? r_sh : trial;
                q_d    = {q_q[WIDTH-2:0], ~bout};
                cnt_d  = cnt_q + CNT_W'(1);
                // Counter wrapping back to zero marks the final iteration
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    quot_d  = {q_q[WIDTH-2:0], ~bout};
                    rem_d   = bout ? r_sh : trial;
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                can_accept = 1'b1;
                state_d    = S_IDLE;
                // Divide-by-zero result is published one cycle after acceptance
                if (dzp_q) begin
                    quot_d = WIDTH'(DZ_QUOT);
                    rem_d  = r_q;
                    dz_d   = 1'b1;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (can_accept && start) begin
            d_d = divisor;
            if (divisor != '0) begin
                q_d     = dividend;
                r_d     = '0;
                cnt_d   = '0;
                busy_d  = 1'b1;
                state_d = S_RUN;
            end else begin
                r_d     = dividend;
                dzp_d   = 1'b1;
                state_d = S_DONE;
            end
        end
    end

    // State, datapath and output registers; clear aborts any operation
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            dzp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            dzp_q   <= dzp_d;
        end
    end

    // Divisor register is only meaningful during RUN, so it has no reset
    always_ff @(posedge clk) begin
        d_q <= d_d;
    end

    assign quot = quot_q;
    assign rem  = rem_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_div8.sv
// Directed and randomized checks for the div8 sequential divider.
module tb_div8;

    logic       clk = 1'b0;
    logic       clear;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quot;
    logic [7:0] rem;
    logic       busy;
    logic       done;
    logic       dz;

    int n_chk = 0;
    int n_err = 0;

    div8 dut (
        .clk      (clk),
        .clear    (clear),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quot     (quot),
        .rem      (rem),
        .busy     (busy),
        .done     (done),
        .dz       (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and let the next rising edge accept it
    task automatic start_op(input logic [7:0] dd, input logic [7:0] dv);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        step();
        start    = 1'b0;
    endtask

    // Wait (bounded) for done; lat counts edges, nb counts busy samples before done
    task automatic wait_done(output int lat, output int nb);
        lat = 0;
        nb  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) nb++;
            step();
            lat++;
        end
    endtask

    int lat, nb, lat2;
    logic [7:0] rd, rv;
    logic [7:0] bq [5]  = '{8'd1, 8'd0, 8'd0, 8'd127, 8'd1};
    logic [7:0] br [5]  = '{8'd0, 8'd0, 8'd254, 8'd1, 8'd72};
    logic [7:0] bdd [5] = '{8'd255, 8'd0, 8'd254, 8'd255, 8'd200};
    logic [7:0] bdv [5] = '{8'd255, 8'd1, 8'd255, 8'd2, 8'd128};

    initial begin
        clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        step(); step();
        chk("rst_quot", 32'(quot), 32'd0);
        chk("rst_rem",  32'(rem),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dz",   32'(dz),   32'd0);
        clear = 1'b0;

        // 200/7
        start_op(8'd200, 8'd7);
        chk("t1_busy_after_accept", 32'(busy), 32'd1);
        wait_done(lat, nb);
        chk("t1_latency", 32'(lat), 32'd8);
        chk("t1_busy_cycles", 32'(nb), 32'd8);
        chk("t1_busy_at_done", 32'(busy), 32'd0);
        chk("t1_quot", 32'(quot), 32'd28);
        chk("t1_rem",  32'(rem),  32'd4);
        chk("t1_dz",   32'(dz),   32'd0);
        step();
        chk("t1_done_pulse_once", 32'(done), 32'd0);
        step();

        // 255/1 then 5/9 with start held in the DONE cycle
        start_op(8'd255, 8'd1);
        wait_done(lat, nb);
        chk("t2a_latency", 32'(lat), 32'd8);
        chk("t2a_quot", 32'(quot), 32'd255);
        chk("t2a_rem",  32'(rem),  32'd0);
        start_op(8'd5, 8'd9);
        chk("t2b_busy_after_accept", 32'(busy), 32'd1);
        chk("t2b_done_cleared", 32'(done), 32'd0);
        wait_done(lat2, nb);
        chk("t2b_gap_between_dones", 32'(lat2 + 1), 32'd9);
        chk("t2b_quot", 32'(quot), 32'd0);
        chk("t2b_rem",  32'(rem),  32'd5);
        step();

        // 100/0 then 9/3
        start_op(8'd100, 8'd0);
        chk("t3_no_busy_on_dz", 32'(busy), 32'd0);
        wait_done(lat, nb);
        chk("t3_latency", 32'(lat), 32'd1);
        chk("t3_quot", 32'(quot), 32'd255);
        chk("t3_rem",  32'(rem),  32'd100);
        chk("t3_dz",   32'(dz),   32'd1);
        step();
        chk("t3_done_pulse_once", 32'(done), 32'd0);
        start_op(8'd9, 8'd3);
        chk("t3b_dz_held_while_running", 32'(dz), 32'd1);
        wait_done(lat, nb);
        chk("t3b_latency", 32'(lat), 32'd8);
        chk("t3b_quot", 32'(quot), 32'd3);
        chk("t3b_rem",  32'(rem),  32'd0);
        chk("t3b_dz",   32'(dz),   32'd0);
        step();

        // 77/5 with an ignored 10/2 request during RUN
        start_op(8'd77, 8'd5);
        step(); step();
        start = 1'b1; dividend = 8'd10; divisor = 8'd2;
        step();
        start = 1'b0;
        wait_done(lat, nb);
        chk("t4_latency", 32'(lat + 3), 32'd8);
        chk("t4_quot", 32'(quot), 32'd15);
        chk("t4_rem",  32'(rem),  32'd2);
        step();

        // 250/3 aborted by an asynchronous clear mid-cycle
        start_op(8'd250, 8'd3);
        step(); step(); step(); step();
        #2;
        clear = 1'b1;
        #1;
        chk("t5_clr_quot", 32'(quot), 32'd0);
        chk("t5_clr_rem",  32'(rem),  32'd0);
        chk("t5_clr_busy", 32'(busy), 32'd0);
        chk("t5_clr_done", 32'(done), 32'd0);
        chk("t5_clr_dz",   32'(dz),   32'd0);
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) nb++;
        end
        chk("t5_no_activity_in_clear", 32'(nb), 32'd0);
        clear = 1'b0;
        start_op(8'd250, 8'd3);
        chk("t5b_accepted_first_edge", 32'(busy), 32'd1);
        wait_done(lat, nb);
        chk("t5b_latency", 32'(lat), 32'd8);
        chk("t5b_quot", 32'(quot), 32'd83);
        chk("t5b_rem",  32'(rem),  32'd1);
        step();

        // Boundary operand table
        for (int i = 0; i < 5; i++) begin
            start_op(bdd[i], bdv[i]);
            wait_done(lat, nb);
            chk($sformatf("bnd%0d_quot", i), 32'(quot), 32'(bq[i]));
            chk($sformatf("bnd%0d_rem", i),  32'(rem),  32'(br[i]));
        end
        step();

        // Random sweep, back-to-back where start lands in DONE
        for (int i = 0; i < 1000; i++) begin
            rd = 8'($urandom_range(0, 255));
            rv = 8'($urandom_range(1, 255));
            start_op(rd, rv);
            wait_done(lat, nb);
            chk("rnd_latency", 32'(lat), 32'd8);
            chk("rnd_identity", 32'(quot) * 32'(rv) + 32'(rem), 32'(rd));
            chk("rnd_rem_lt_div", 32'(rem < rv), 32'd1);
        end
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
